// File: rtl/uart_prog_loader.sv
// Program loader: packs UART bytes little-endian into 32-bit words, writes them to
// consecutive instruction-memory cells and holds the CPU in reset until the image is complete.
module uart_prog_loader #(
  parameter int CELL_NUMBERS = 64,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(CELL_NUMBERS);

  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_RUN} state_t;

  state_t          state;
  logic [1:0]      byte_idx;
  logic [31:0]     asm_word;
  logic [ADDR_W:0] cnt_inc;

  assign cnt_inc = word_cnt + (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_LOAD;
      byte_idx  <= 2'd0;
      asm_word  <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      word_cnt  <= '0;
    end else if (reload) begin
      // reload beats any coincident byte and drops a partial word
      state     <= S_LOAD;
      byte_idx  <= 2'd0;
      asm_word  <= 32'd0;
      mem_we    <= 1'b0;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      word_cnt  <= '0;
    end else begin
      case (state)
        S_LOAD: if (rx_valid) begin
          asm_word[{byte_idx, 3'b000} +: 8] <= rx_data;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            state     <= S_WRITE;
            mem_we    <= 1'b1;
            mem_addr  <= word_cnt[ADDR_W-1:0];
            mem_wdata <= {rx_data, asm_word[23:0]};
          end
        end
        S_WRITE: begin
          mem_we   <= 1'b0;
          word_cnt <= cnt_inc;
          if (cnt_inc == LAST_CNT) begin
            state     <= S_RUN;
            load_done <= 1'b1;
            cpu_rst   <= 1'b0;
          end else begin
            state <= S_LOAD;
          end
          // an early byte starts the next word rather than being lost
          if (rx_valid) begin
            asm_word[7:0] <= rx_data;
            byte_idx      <= 2'd1;
          end
        end
        S_RUN: ;
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed steps plus random byte streams, checked against a
// transaction-level model that packs bytes into expected (address, word) writes.
module tb_uart_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        reload;

  logic        we4, cpurst4, done4;
  logic [2:0]  addr4;
  logic [31:0] wdata4;
  logic [3:0]  cnt4;

  logic        we1, cpurst1, done1;
  logic [0:0]  addr1;
  logic [31:0] wdata1;
  logic [1:0]  cnt1;

  int vecs = 0;
  int miss = 0;

  uart_prog_loader #(.CELL_NUMBERS(4), .ADDR_W(3)) u4 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .reload(reload),
    .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4), .cpu_rst(cpurst4),
    .load_done(done4), .word_cnt(cnt4));

  uart_prog_loader #(.CELL_NUMBERS(1), .ADDR_W(1)) u1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .reload(reload),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .cpu_rst(cpurst1),
    .load_done(done1), .word_cnt(cnt1));

  always #5 clk = ~clk;

  // reference model for the 4-word instance
  logic [7:0]  part_q[$];
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  int          m_cnt  = 0;
  bit          m_done = 1'b0;

  always @(negedge clk) if (we4 === 1'b1) obs_q.push_back({5'b0, addr4, wdata4});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reload();
    part_q.delete();
    m_cnt  = 0;
    m_done = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_done) return;
    part_q.push_back(b);
    if (part_q.size() == 4) begin
      exp_q.push_back({8'(m_cnt), part_q[3], part_q[2], part_q[1], part_q[0]});
      m_cnt++;
      if (m_cnt == 4) m_done = 1'b1;
      part_q.delete();
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit r);
    rx_valid = v;
    rx_data  = d;
    reload   = r;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
    model_byte(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reload();
    step(1'b0, 8'h00, 1'b1);
    model_reload();
  endtask

  task automatic drain(input string tag);
    chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) chk(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_cnt"}, cnt4, m_cnt);
    chk({tag, "_done"}, done4, m_done);
    chk({tag, "_cpurst"}, cpurst4, !m_done);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    int guard;
    rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; reload = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpurst", cpurst4, 1'b1);
    chk("rst_done", done4, 1'b0);
    chk("rst_we", we4, 1'b0);
    chk("rst_cnt", cnt4, 4'd0);
    chk("rst_addr", addr4, 3'd0);
    chk("rst_wdata", wdata4, 32'd0);
    chk("rst_cpurst1", cpurst1, 1'b1);
    rst = 1'b1;
    idle(1);

    // single word: the 1-cell instance completes, the 4-cell one keeps loading
    send(8'h33); send(8'h62); send(8'h21); send(8'h00);
    chk("w1_we", we1, 1'b1);
    chk("w1_addr", addr1, 1'b0);
    chk("w1_data", wdata1, 32'h00216233);
    chk("w1_done_early", done1, 1'b0);
    idle(1);
    chk("w1_done", done1, 1'b1);
    chk("w1_cpurst", cpurst1, 1'b0);
    chk("w1_we_off", we1, 1'b0);
    chk("w1_cnt", cnt1, 2'd1);
    chk_status("w1_u4");
    drain("w1_u4");

    // full 4-word load with spaced bytes
    do_reload();
    chk_status("full_start");
    for (int i = 0; i < 15; i++) begin send(8'(i)); idle(1); end
    send(8'h0F);
    chk("full_we", we4, 1'b1);
    chk("full_addr", addr4, 3'd3);
    chk("full_data", wdata4, 32'h0F0E0D0C);
    chk("full_done_early", done4, 1'b0);
    idle(1);
    chk("full_we_off", we4, 1'b0);
    chk_status("full_end");
    idle(1);
    drain("full");
    for (int i = 0; i < 4; i++) send(8'hFF);
    idle(2);
    drain("run_extra");
    chk("run_cnt", cnt4, 4'd4);
    chk("run_cnt1", cnt1, 2'd1);

    // reload from RUN
    do_reload();
    chk_status("reload_run");

    // back-to-back strobes, including one during the write cycle
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
    idle(2);
    drain("b2b");
    chk_status("b2b");

    // partial-word reload, and reload coinciding with a byte
    step(1'b1, 8'h99, 1'b1); model_reload();
    send(8'hAA); send(8'hBB);
    do_reload();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(2);
    drain("partial");
    chk("partial_word", wdata4, 32'h04030201);
    chk("partial_addr", addr4, 3'd0);
    chk_status("partial");

    // asynchronous reset in the middle of a write cycle
    do_reload();
    for (int i = 0; i < 4; i++) send(8'($urandom));
    idle(1);
    drain("prerst");
    for (int i = 0; i < 4; i++) send(8'($urandom));
    chk("prerst_we", we4, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_we", we4, 1'b0);
    chk("arst_cnt", cnt4, 4'd0);
    chk("arst_cpurst", cpurst4, 1'b1);
    chk("arst_done", done4, 1'b0);
    chk("arst_addr", addr4, 3'd0);
    chk("arst_wdata", wdata4, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    obs_q.delete(); exp_q.delete(); model_reload();
    idle(1);
    chk_status("after_rst");

    // random programs with gaps, bursts and mid-word reloads
    for (int p = 0; p < 4; p++) begin
      do_reload();
      guard = 0;
      while (!m_done && guard < 400) begin
        guard++;
        b = 8'($urandom);
        if (part_q.size() inside {[1:3]} && $urandom_range(0, 19) == 0) begin
          step(1'($urandom_range(0, 1)), b, 1'b1);
          model_reload();
        end else if ($urandom_range(0, 2) != 0) begin
          send(b);
        end else begin
          idle(1);
        end
      end
      idle(2);
      drain("rnd");
      chk_status("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
